spc_alu_unit: RTL and testbench

Parametrised, multi-cycle execute unit for the SPC700 core. It replaces the single-cycle, flagless compute stage with a valid/ready-handshaked ALU. The ALU produces architecturally correct N/V/H/Z/C flags, shifts/rotates, INC/DEC, and iterative MUL and DIV. It sits between decode/operand-fetch and write-back.

---
 rtl/spc_pkg.sv | 46 ++++
 rtl/spc_alu_unit_if.sv | 36 +++
 rtl/spc_alu_iter.sv | 106 ++++++++++
 rtl/spc_alu_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_spc_alu_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/spc_pkg.sv
//------------------------------------------------------------------------------
// Module      : spc_pkg
// Description : Shared op codes, PSW bit positions and execute-unit states
//               for the SPC700 execute unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spc_pkg;

    localparam logic [4:0] OP_OR     = 5'd0;
    localparam logic [4:0] OP_AND    = 5'd1;
    localparam logic [4:0] OP_EOR    = 5'd2;
    localparam logic [4:0] OP_ANDN   = 5'd3;
    localparam logic [4:0] OP_ADC    = 5'd4;
    localparam logic [4:0] OP_SBC    = 5'd5;
    localparam logic [4:0] OP_CMP    = 5'd6;
    localparam logic [4:0] OP_PASS_A = 5'd7;
    localparam logic [4:0] OP_PASS_B = 5'd8;
    localparam logic [4:0] OP_ASL    = 5'd9;
    localparam logic [4:0] OP_LSR    = 5'd10;
    localparam logic [4:0] OP_ROL    = 5'd11;
    localparam logic [4:0] OP_ROR    = 5'd12;
    localparam logic [4:0] OP_INC    = 5'd13;
    localparam logic [4:0] OP_DEC    = 5'd14;
    localparam logic [4:0] OP_MUL    = 5'd15;
    localparam logic [4:0] OP_DIV    = 5'd16;

    localparam int PSW_N = 0;
    localparam int PSW_V = 1;
    localparam int PSW_P = 2;
    localparam int PSW_B = 3;
    localparam int PSW_H = 4;
    localparam int PSW_I = 5;
    localparam int PSW_Z = 6;
    localparam int PSW_C = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spc_alu_unit_if.sv
//------------------------------------------------------------------------------
// Module      : spc_alu_unit_if
// Description : Operation-in / result-out handshake bundle of the execute unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spc_alu_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_hi;
    logic [7:0]       in_psw;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [WIDTH-1:0] out_result_hi;
    logic [7:0]       out_psw;
    logic             out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, in_hi, in_psw, out_ready,
        input  in_ready, out_valid, out_result, out_result_hi, out_psw, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_hi, in_psw, out_ready,
        output in_ready, out_valid, out_result, out_result_hi, out_psw, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/spc_alu_iter.sv
//------------------------------------------------------------------------------
// Module      : spc_alu_iter
// Description : Shift-add multiply / restoring divide datapath with step
//               counter; divider built only with SPC_ALU_DIV_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spc_alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
`ifdef SPC_ALU_DIV_EN
    input  logic             div_mode,
    input  logic [WIDTH-1:0] hi,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q,  lo_d;
    logic [WIDTH-1:0] b_q,   b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   w_mul_sum;
`ifdef SPC_ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ok;
`endif

    assign last = (cnt_q == '0);

    always_comb begin
        // acc:lo shifts right one place per step, product ends up in {acc, lo}
        w_mul_sum = {1'b0, acc_q} + {1'b0, b_q & {WIDTH{lo_q[0]}}};
        nxt_hi    = w_mul_sum[WIDTH:1];
        nxt_lo    = {w_mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef SPC_ALU_DIV_EN
        // acc is the partial remainder, lo collects quotient bits from the right
        w_div_shift = {acc_q, lo_q[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, b_q};
        w_div_ok    = ~w_div_diff[WIDTH];
        if (div_q) begin
            nxt_hi = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            nxt_lo = {lo_q[WIDTH-2:0], w_div_ok};
        end
`endif
    end

    always_comb begin
        acc_d = acc_q;
        lo_d  = lo_q;
        b_d   = b_q;
        cnt_d = cnt_q;
`ifdef SPC_ALU_DIV_EN
        div_d = div_q;
`endif
        if (load) begin
            acc_d = '0;
            lo_d  = a;
            b_d   = b;
            cnt_d = CW'(WIDTH - 1);
`ifdef SPC_ALU_DIV_EN
            div_d = div_mode;
            if (div_mode) acc_d = hi;
`endif
        end else if (step) begin
            acc_d = nxt_hi;
            lo_d  = nxt_lo;
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
`ifdef SPC_ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
`ifdef SPC_ALU_DIV_EN
            div_q <= div_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/spc_alu_unit.sv
//------------------------------------------------------------------------------
// Module      : spc_alu_unit
// Description : Handshaked SPC700 execute unit with flags, MUL and optional
//               DIV (enabled by SPC_ALU_DIV_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spc_alu_unit
    import spc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    spc_alu_unit_if.slave bus
);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [7:0]       psw_q, psw_d;
    logic             illegal_q, illegal_d;
    logic [7:0]       psw_hold_q, psw_hold_d;

    logic             w_in_ready;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [4:0]       w_hsum;
    logic [WIDTH-1:0] w_sc_result, w_sc_hi;
    logic [7:0]       w_sc_psw;
    logic             w_sc_illegal, w_sc_start_mul, w_sc_start_div;
    logic             w_iter_load, w_iter_step, w_iter_last;
    logic [WIDTH-1:0] w_iter_hi, w_iter_lo;
    logic             w_done;
    logic [WIDTH-1:0] w_done_result, w_done_hi;
    logic [7:0]       w_done_psw;
    logic             w_done_illegal;
`ifdef SPC_ALU_DIV_EN
    logic             w_iter_div;
`endif

    function automatic logic [7:0] set_nz(input logic [7:0] psw, input logic [WIDTH-1:0] word);
        logic [7:0] r;
        r        = psw;
        r[PSW_N] = word[WIDTH-1];
        r[PSW_Z] = (word == '0);
        return r;
    endfunction

    assign w_in_ready        = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = result_q;
    assign bus.out_result_hi = result_hi_q;
    assign bus.out_psw       = psw_q;
    assign bus.out_illegal   = illegal_q;

    always_comb begin
        // One adder serves ADC, SBC (a + ~b + C) and CMP (a + ~b + 1)
        w_b_eff = (bus.in_op == OP_ADC) ? bus.in_b : ~bus.in_b;
        w_cin   = (bus.in_op == OP_CMP) ? 1'b1 : bus.in_psw[PSW_C];
        w_sum   = {1'b0, bus.in_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
        w_hsum  = {1'b0, bus.in_a[3:0]} + {1'b0, w_b_eff[3:0]} + {4'b0, w_cin};

        w_sc_result    = '0;
        w_sc_hi        = '0;
        w_sc_psw       = bus.in_psw;
        w_sc_illegal   = 1'b0;
        w_sc_start_mul = 1'b0;
        w_sc_start_div = 1'b0;
        case (bus.in_op)
            OP_OR:     w_sc_result = bus.in_a | bus.in_b;
            OP_AND:    w_sc_result = bus.in_a & bus.in_b;
            OP_EOR:    w_sc_result = bus.in_a ^ bus.in_b;
            OP_ANDN:   w_sc_result = bus.in_a & ~bus.in_b;
            OP_PASS_A: w_sc_result = bus.in_a;
            OP_PASS_B: w_sc_result = bus.in_b;
            OP_ADC, OP_SBC: begin
                w_sc_result     = w_sum[WIDTH-1:0];
                w_sc_psw[PSW_C] = w_sum[WIDTH];
                w_sc_psw[PSW_H] = w_hsum[4];
                w_sc_psw[PSW_V] = (bus.in_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                                  (w_sum[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_CMP: begin
                w_sc_result     = bus.in_a;
                w_sc_psw[PSW_C] = w_sum[WIDTH];
            end
            OP_ASL: begin
                w_sc_result     = {bus.in_a[WIDTH-2:0], 1'b0};
                w_sc_psw[PSW_C] = bus.in_a[WIDTH-1];
            end
            OP_LSR: begin
                w_sc_result     = {1'b0, bus.in_a[WIDTH-1:1]};
                w_sc_psw[PSW_C] = bus.in_a[0];
            end
            OP_ROL: begin
                w_sc_result     = {bus.in_a[WIDTH-2:0], bus.in_psw[PSW_C]};
                w_sc_psw[PSW_C] = bus.in_a[WIDTH-1];
            end
            OP_ROR: begin
                w_sc_result     = {bus.in_psw[PSW_C], bus.in_a[WIDTH-1:1]};
                w_sc_psw[PSW_C] = bus.in_a[0];
            end
            OP_INC:    w_sc_result = bus.in_a + WIDTH'(1);
            OP_DEC:    w_sc_result = bus.in_a - WIDTH'(1);
            OP_MUL:    w_sc_start_mul = 1'b1;
`ifdef SPC_ALU_DIV_EN
            OP_DIV: begin
                w_sc_psw[PSW_H] = (bus.in_hi[3:0] >= bus.in_b[3:0]);
                // Quotient cannot fit (includes divide by zero): saturate at once
                if (bus.in_hi >= bus.in_b) begin
                    w_sc_result     = '1;
                    w_sc_hi         = bus.in_hi;
                    w_sc_psw[PSW_V] = 1'b1;
                end else begin
                    w_sc_psw[PSW_V] = 1'b0;
                    w_sc_start_div  = 1'b1;
                end
            end
`endif
            default:   w_sc_illegal = 1'b1;
        endcase

        if (!w_sc_illegal && !w_sc_start_mul && !w_sc_start_div)
            w_sc_psw = set_nz(w_sc_psw, (bus.in_op == OP_CMP) ? w_sum[WIDTH-1:0] : w_sc_result);
    end

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        result_d       = result_q;
        result_hi_d    = result_hi_q;
        psw_d          = psw_q;
        illegal_d      = illegal_q;
        psw_hold_d     = psw_hold_q;
        w_iter_load    = 1'b0;
        w_iter_step    = 1'b0;
`ifdef SPC_ALU_DIV_EN
        w_iter_div     = 1'b0;
`endif
        w_done         = 1'b0;
        w_done_result  = w_sc_result;
        w_done_hi      = w_sc_hi;
        w_done_psw     = w_sc_psw;
        w_done_illegal = w_sc_illegal;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && w_in_ready) begin
                    if (w_sc_start_mul) begin
                        w_iter_load = 1'b1;
                        psw_hold_d  = w_sc_psw;
                        state_d     = ST_MUL;
                    end
`ifdef SPC_ALU_DIV_EN
                    else if (w_sc_start_div) begin
                        w_iter_load = 1'b1;
                        w_iter_div  = 1'b1;
                        psw_hold_d  = w_sc_psw;
                        state_d     = ST_DIV;
                    end
`endif
                    else begin
                        w_done = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                w_iter_step = 1'b1;
                if (w_iter_last) begin
                    w_done         = 1'b1;
                    w_done_result  = w_iter_lo;
                    w_done_hi      = w_iter_hi;
                    w_done_psw     = set_nz(psw_hold_q, w_iter_hi);
                    w_done_illegal = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
`ifdef SPC_ALU_DIV_EN
            ST_DIV: begin
                w_iter_step = 1'b1;
                if (w_iter_last) begin
                    w_done         = 1'b1;
                    w_done_result  = w_iter_lo;
                    w_done_hi      = w_iter_hi;
                    w_done_psw     = set_nz(psw_hold_q, w_iter_lo);
                    w_done_illegal = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (w_done) begin
            out_valid_d = 1'b1;
            result_d    = w_done_result;
            result_hi_d = w_done_hi;
            psw_d       = w_done_psw;
            illegal_d   = w_done_illegal;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            psw_q       <= '0;
            illegal_q   <= 1'b0;
            psw_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            psw_q       <= psw_d;
            illegal_q   <= illegal_d;
            psw_hold_q  <= psw_hold_d;
        end
    end

    spc_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clock    (clock),
        .reset    (reset),
        .load     (w_iter_load),
        .step     (w_iter_step),
`ifdef SPC_ALU_DIV_EN
        .div_mode (w_iter_div),
        .hi       (bus.in_hi),
`endif
        .a        (bus.in_a),
        .b        (bus.in_b),
        .last     (w_iter_last),
        .nxt_hi   (w_iter_hi),
        .nxt_lo   (w_iter_lo)
    );

endmodule

`default_nettype wire

// File: tb/tb_spc_alu_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_spc_alu_unit
// Description : Directed self-checking bench for spc_alu_unit at WIDTH=8;
//               DIV cases follow SPC_ALU_DIV_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spc_alu_unit;
    import spc_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    spc_alu_unit_if #(.WIDTH(8)) alu_if ();

    spc_alu_unit #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (alu_if)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input string tag, input logic [4:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] hi, input logic [7:0] psw);
        alu_if.in_valid = 1'b1;
        alu_if.in_op    = op;
        alu_if.in_a     = a;
        alu_if.in_b     = b;
        alu_if.in_hi    = hi;
        alu_if.in_psw   = psw;
        #1;
        for (int g = 0; g < 40 && !alu_if.in_ready; g++) tick();
        check_eq({tag, "_in_ready"}, 32'(alu_if.in_ready), 32'd1);
        tick();
        alu_if.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int lat_exp, input logic [7:0] res,
                              input logic [7:0] hi, input logic [7:0] psw, input logic ill);
        int   lat = 0;
        logic rdy_seen = 1'b0;
        while (!alu_if.out_valid && lat < 40) begin
            if (alu_if.in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check_eq({tag, "_result"},  32'(alu_if.out_result), 32'(res));
        check_eq({tag, "_hi"},      32'(alu_if.out_result_hi), 32'(hi));
        check_eq({tag, "_psw"},     32'(alu_if.out_psw), 32'(psw));
        check_eq({tag, "_illegal"}, 32'(alu_if.out_illegal), 32'(ill));
        if (lat_exp > 0) check_eq({tag, "_busy_in_ready"}, 32'(rdy_seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        alu_if.in_valid  = 1'b0;
        alu_if.in_op     = '0;
        alu_if.in_a      = '0;
        alu_if.in_b      = '0;
        alu_if.in_hi     = '0;
        alu_if.in_psw    = '0;
        alu_if.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check_eq("rst_out_valid", 32'(alu_if.out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(alu_if.in_ready), 32'd1);
        check_eq("rst_result",    32'(alu_if.out_result), 32'd0);
        check_eq("rst_hi",        32'(alu_if.out_result_hi), 32'd0);
        check_eq("rst_psw",       32'(alu_if.out_psw), 32'd0);
        check_eq("rst_illegal",   32'(alu_if.out_illegal), 32'd0);

        // Back-to-back single-cycle ops: each result replaces the previous with no bubble
        issue("adc", OP_ADC, 8'h7F, 8'h01, 8'h00, 8'h00); expect_out("adc", 0, 8'h80, 8'h00, 8'h13, 1'b0);
        issue("sbc", OP_SBC, 8'h00, 8'h01, 8'h00, 8'h88); expect_out("sbc", 0, 8'hFF, 8'h00, 8'h09, 1'b0);
        issue("cmp", OP_CMP, 8'h40, 8'h40, 8'h00, 8'h12); expect_out("cmp", 0, 8'h40, 8'h00, 8'hD2, 1'b0);
        issue("asl", OP_ASL, 8'h81, 8'h00, 8'h00, 8'h00); expect_out("asl", 0, 8'h02, 8'h00, 8'h80, 1'b0);
        issue("ror", OP_ROR, 8'h01, 8'h00, 8'h00, 8'h80); expect_out("ror", 0, 8'h80, 8'h00, 8'h81, 1'b0);
        issue("inc", OP_INC, 8'hFF, 8'h00, 8'h00, 8'h80); expect_out("inc", 0, 8'h00, 8'h00, 8'hC0, 1'b0);
        issue("ill", 5'd20,  8'h12, 8'h34, 8'h00, 8'hA5); expect_out("ill", 0, 8'h00, 8'h00, 8'hA5, 1'b1);
        tick();
        check_eq("drain_out_valid", 32'(alu_if.out_valid), 32'd0);

        issue("mul", OP_MUL, 8'h12, 8'h34, 8'h00, 8'h41); expect_out("mul", 8, 8'hA8, 8'h03, 8'h00, 1'b0);
`ifdef SPC_ALU_DIV_EN
        issue("div", OP_DIV, 8'h64, 8'h07, 8'h00, 8'h12); expect_out("div", 8, 8'h0E, 8'h02, 8'h00, 1'b0);
        issue("div_ovf", OP_DIV, 8'h00, 8'h03, 8'h05, 8'h00);
        expect_out("div_ovf", 0, 8'hFF, 8'h05, 8'h13, 1'b0);
`else
        issue("div_off", OP_DIV, 8'h64, 8'h07, 8'h00, 8'h5A);
        expect_out("div_off", 0, 8'h00, 8'h00, 8'h5A, 1'b1);
`endif
        tick();

        // Backpressure: result held, next op waits until out_ready rises
        alu_if.out_ready = 1'b0;
        issue("bp_first", OP_EOR, 8'h3C, 8'h0F, 8'h00, 8'h00);
        expect_out("bp_first", 0, 8'h33, 8'h00, 8'h00, 1'b0);
        alu_if.in_valid = 1'b1;
        alu_if.in_op    = OP_AND;
        alu_if.in_a     = 8'hF0;
        alu_if.in_b     = 8'hC3;
        alu_if.in_psw   = 8'h00;
        #1;
        check_eq("bp_in_ready_low", 32'(alu_if.in_ready), 32'd0);
        tick();
        tick();
        check_eq("bp_hold_valid",  32'(alu_if.out_valid), 32'd1);
        check_eq("bp_hold_result", 32'(alu_if.out_result), 32'h33);
        check_eq("bp_hold_psw",    32'(alu_if.out_psw), 32'h00);
        alu_if.out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_up", 32'(alu_if.in_ready), 32'd1);
        tick();
        alu_if.in_valid = 1'b0;
        check_eq("bp_new_valid",  32'(alu_if.out_valid), 32'd1);
        check_eq("bp_new_result", 32'(alu_if.out_result), 32'hC0);
        check_eq("bp_new_psw",    32'(alu_if.out_psw), 32'h01);
        tick();

        // Reset lands on the 4th multiply iteration
        issue("mul_rst", OP_MUL, 8'h12, 8'h34, 8'h00, 8'h00);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("mrst_out_valid", 32'(alu_if.out_valid), 32'd0);
        check_eq("mrst_in_ready",  32'(alu_if.in_ready), 32'd1);
        check_eq("mrst_result",    32'(alu_if.out_result), 32'd0);
        check_eq("mrst_hi",        32'(alu_if.out_result_hi), 32'd0);
        check_eq("mrst_psw",       32'(alu_if.out_psw), 32'd0);
        check_eq("mrst_illegal",   32'(alu_if.out_illegal), 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (alu_if.out_valid) seen = 1'b1;
        end
        check_eq("mrst_no_partial", 32'(seen), 32'd0);
        issue("or_after_rst", OP_OR, 8'h0F, 8'hF0, 8'h00, 8'h00);
        expect_out("or_after_rst", 0, 8'hFF, 8'h00, 8'h01, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
